iter_counter: RTL and testbench
===============================

Name: iter_counter

Overview:
Parametrised iteration counter for multi-cycle datapath units such as the iterative multiplier and divider. It generalises the fixed 6-bit free-running counter with compare. Additions:
- WIDTH parameter.
- start/busy/ready handshake.
- Terminal count latched at start.
- Up or down counting mode.
- Stall and abort controls.
- An early "last iteration" flag.

The owning unit's control FSM drives it, and the unit's datapath consumes cnt/last.

Parameters:
WIDTH, 6, bit width of the count, of n and of the terminal register (WIDTH >= 2)

Ports:
clk      input   1      system clock, rising edge
clr_n    input   1      reset; one clock; reset is asynchronous and active-low
start    input   1      request a new count sequence; sampled only when not busy
abort    input   1      synchronous cancel of the current sequence
stall    input   1      hold the count this cycle (no advance, no termination)
mode     input   1      0 = count up from 0 to n; 1 = count down from n to 0; latched at start
n        input   WIDTH  terminal/initial value; latched at start
cnt      output  WIDTH  current count (registered)
busy     output  1      sequence in progress (registered)
last     output  1      combinational: busy & ~stall & (cnt == terminal)
ready    output  1      one-cycle pulse: sequence finished (registered)

Behaviour:
- Internal state is IDLE or RUN. The latched registers are n_q and mode_q. Terminal is n_q when mode_q=0, else 0.
- Reset (clr_n=0, any time, including mid-sequence): state=IDLE; cnt=0; busy=0; ready=0; n_q=0; mode_q=0. Effect is immediate and needs no clock.
- Per-edge priority: abort > termination > start > count.
- IDLE:
  - start=1 → n_q<=n, mode_q<=mode, cnt<=(mode ? n : 0), busy<=1, state<=RUN.
  - stall is ignored in IDLE.
  - With no start, cnt holds its last value.
- RUN, stall=1: cnt, busy and state hold. ready=0. last=0.
- RUN, stall=0, cnt != terminal: cnt<=cnt+1 (up) or cnt-1 (down).
- RUN, stall=0, cnt == terminal:
  - busy<=0, ready<=1, state<=IDLE.
  - cnt holds the terminal value.
- ready is high for exactly one cycle, then returns to 0.
- start asserted while busy=1 is ignored; it is neither queued nor restarted.
- start asserted in the cycle where ready=1 (state already IDLE) is accepted. This allows back-to-back sequences with no gap cycle.
- Latency: with the start edge as edge 0, busy is high for n_q+1 cycles plus stalled cycles. ready rises at edge n_q+1+stalls.
- n=0: one busy cycle. last=1 in that cycle (if not stalled). ready follows on the next edge.
- n = 2^WIDTH-1: up mode reaches all-ones and terminates there. The count never wraps. Down mode starts at all-ones.
- abort=1 at any edge: state<=IDLE, busy<=0, cnt<=0, ready<=0. No ready pulse is produced for the aborted sequence. start in the same cycle is ignored.
- Changes to n/mode while busy have no effect. Only the latched copies are used.
- All arithmetic is unsigned WIDTH-bit. The compare is exact equality against the terminal value.

Test Plan:
1. Reset, then WIDTH=6, mode=0, n=5, 1-cycle start → cnt 0,1,2,3,4,5 on successive cycles. busy high 6 cycles. last high only while cnt=5. ready pulses once on the next edge. cnt stays 5.
2. mode=1, n=3, stall high for 2 cycles while cnt=2 → cnt 3,2,2,2,1,0. busy high 6 cycles. last=0 during stall. ready one pulse after cnt=0.
3. n=0 → busy 1 cycle with last=1. ready on the next edge. Then start in the ready cycle with n=2 → new sequence 0,1,2 with no idle gap.
4. Change n from 4 to 1 and pulse start mid-sequence → sequence completes at 4. Second start is ignored. Exactly one ready pulse.
5. abort at cnt=3 of n=10 → next cycle cnt=0, busy=0, no ready pulse. Then drive clr_n low asynchronously mid-sequence → cnt/busy/ready clear before the next clk edge.
6. WIDTH=4, mode=0, n=15 → counts 0..15 without wrap. ready after 16 busy cycles. cnt holds 15.

Source files
------------

// File: rtl/iter_counter.sv
// Iteration counter for multi-cycle datapath units.
// Counts up to, or down from, a terminal value latched at start.
module iter_counter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic             abort,
  input  logic             stall,
  input  logic             mode,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             last,
  output logic             ready
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [WIDTH-1:0] ONE =
    {{(WIDTH-1){1'b0}}, 1'b1};

  logic [0:0]       state_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] n_q;
  logic             mode_q;
  logic             ready_q;
  logic [WIDTH-1:0] term;
  logic             at_term;

  // Down-counting sequences end at zero.
  assign term    = mode_q ? '0 : n_q;
  assign at_term = (cnt_q == term);

  assign cnt   = cnt_q;
  assign busy  = (state_q == RUN);
  assign ready = ready_q;
  assign last  = busy & ~stall & at_term;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      mode_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else if (state_q == RUN) begin
        if (!stall) begin
          if (at_term) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end else if (mode_q) begin
            cnt_q <= cnt_q - ONE;
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
      end else if (start) begin
        state_q <= RUN;
        n_q     <= n;
        mode_q  <= mode;
        cnt_q   <= mode ? n : '0;
      end
    end
  end

endmodule

// File: tb/tb_iter_counter.sv
// Bench for iter_counter: directed scenarios plus random
// traffic against a step-index reference model.
module tb_iter_counter;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         clr_n;
  logic         start, abort, stall, mode;
  logic [W-1:0] n, cnt;
  logic         busy, last, ready;

  logic         s4_start;
  logic         z4 = 1'b0;
  logic [3:0]   n4, cnt4;
  logic         busy4, last4, ready4;

  int checks = 0;
  int errors = 0;

  // Model: a sequence is "step index idx of n"; cnt derives from it.
  bit m_act, m_mode, m_ready;
  int m_idx, m_n, m_hold;
  bit exp_last, obs_last;

  always #5 clk = ~clk;

  iter_counter #(.WIDTH(W)) dut (
    .clk(clk), .clr_n(clr_n), .start(start),
    .abort(abort), .stall(stall), .mode(mode),
    .n(n), .cnt(cnt), .busy(busy), .last(last),
    .ready(ready)
  );

  iter_counter #(.WIDTH(4)) dut4 (
    .clk(clk), .clr_n(clr_n), .start(s4_start),
    .abort(z4), .stall(z4), .mode(z4),
    .n(n4), .cnt(cnt4), .busy(busy4), .last(last4),
    .ready(ready4)
  );

  function automatic logic [W-1:0] m_cnt();
    if (!m_act) return W'(m_hold);
    return m_mode ? W'(m_n - m_idx) : W'(m_idx);
  endfunction

  task automatic m_reset();
    m_act = 0; m_mode = 0; m_ready = 0;
    m_idx = 0; m_n = 0; m_hold = 0;
  endtask

  task automatic step(input bit st, input bit ab,
                      input bit sl, input bit md,
                      input int nv);
    start = st; abort = ab; stall = sl; mode = md;
    n = W'(nv);
    #1;
    obs_last = last;
    exp_last = m_act && !sl && (m_idx == m_n);
    @(posedge clk);
    m_ready = 0;
    if (ab) begin
      m_act = 0; m_hold = 0;
    end else if (m_act) begin
      if (!sl) begin
        if (m_idx == m_n) begin
          m_hold = int'(m_cnt());
          m_act = 0; m_ready = 1;
        end else m_idx++;
      end
    end else if (st) begin
      m_act = 1; m_idx = 0; m_n = nv; m_mode = md;
    end
    @(negedge clk);
    start = 0; abort = 0; stall = 0;
  endtask

  task automatic test_reset();
    clr_n = 0; start = 0; abort = 0; stall = 0;
    mode = 0; n = '0; s4_start = 0; n4 = '0;
    m_reset();
    #3;
    checks++;
    if ({cnt, busy, ready, last} !== {W'(0), 3'b000}) begin
      errors++;
      $display("FAIL reset: cnt=%0d busy=%b ready=%b last=%b want 0 0 0 0",
               cnt, busy, ready, last);
    end
    @(negedge clk);
    clr_n = 1;
    @(negedge clk);
  endtask

  task automatic test_up_basic();
    int bcnt = 0, rcnt = 0, lcnt = 0;
    step(1, 0, 0, 0, 5);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if ({cnt, busy, ready, obs_last} !==
          {m_cnt(), m_act, m_ready, exp_last}) begin
        errors++;
        $display("FAIL up_basic[%0d]: got %0d/%b/%b/%b want %0d/%b/%b/%b",
                 i, cnt, busy, ready, obs_last,
                 m_cnt(), m_act, m_ready, exp_last);
      end
      bcnt += int'(busy); rcnt += int'(ready);
      step(0, 0, 0, 0, 0);
      lcnt += int'(obs_last);
    end
    checks++;
    if (bcnt != 6 || rcnt != 1 || lcnt != 1 || cnt !== W'(5)) begin
      errors++;
      $display("FAIL up_summary: busy=%0d ready=%0d last=%0d cnt=%0d want 6 1 1 5",
               bcnt, rcnt, lcnt, cnt);
    end
  endtask

  task automatic test_down_stall();
    int bcnt = 0, rcnt = 0;
    bit sl;
    step(1, 0, 0, 1, 3);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({cnt, busy, ready, obs_last} !==
          {m_cnt(), m_act, m_ready, exp_last}) begin
        errors++;
        $display("FAIL down_stall[%0d]: got %0d/%b/%b/%b want %0d/%b/%b/%b",
                 i, cnt, busy, ready, obs_last,
                 m_cnt(), m_act, m_ready, exp_last);
      end
      bcnt += int'(busy); rcnt += int'(ready);
      sl = (i == 1 || i == 2);
      step(0, 0, sl, 0, 0);
      if (sl) begin
        checks++;
        if (obs_last !== 1'b0) begin
          errors++;
          $display("FAIL stall_last: got %b want 0", obs_last);
        end
      end
    end
    checks++;
    if (bcnt != 6 || rcnt != 1 || cnt !== W'(0)) begin
      errors++;
      $display("FAIL down_summary: busy=%0d ready=%0d cnt=%0d want 6 1 0",
               bcnt, rcnt, cnt);
    end
  endtask

  task automatic test_back_to_back();
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    checks++;
    if (obs_last !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL n0: last=%b ready=%b busy=%b want 1 1 0",
               obs_last, ready, busy);
    end
    for (int i = 0; i < 5; i++) begin
      step(i == 0, 0, 0, 0, 2);
      checks++;
      if ({cnt, busy, ready, obs_last} !==
          {m_cnt(), m_act, m_ready, exp_last}) begin
        errors++;
        $display("FAIL b2b[%0d]: got %0d/%b/%b/%b want %0d/%b/%b/%b",
                 i, cnt, busy, ready, obs_last,
                 m_cnt(), m_act, m_ready, exp_last);
      end
    end
  endtask

  task automatic test_start_busy();
    int rcnt = 0;
    step(1, 0, 0, 0, 4);
    for (int i = 0; i < 8; i++) begin
      step(i == 1, 0, 0, i[0], (i == 1) ? 1 : 7);
      rcnt += int'(ready);
      checks++;
      if ({cnt, busy, ready} !== {m_cnt(), m_act, m_ready}) begin
        errors++;
        $display("FAIL start_busy[%0d]: got %0d/%b/%b want %0d/%b/%b",
                 i, cnt, busy, ready, m_cnt(), m_act, m_ready);
      end
    end
    checks++;
    if (rcnt != 1 || cnt !== W'(4)) begin
      errors++;
      $display("FAIL start_busy_sum: ready=%0d cnt=%0d want 1 4", rcnt, cnt);
    end
  endtask

  task automatic test_abort_reset();
    int rcnt = 0;
    step(1, 0, 0, 0, 10);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    checks++;
    if (cnt !== W'(3)) begin
      errors++;
      $display("FAIL pre_abort: cnt=%0d want 3", cnt);
    end
    step(1, 1, 0, 0, 5);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({cnt, busy, ready} !== {W'(0), 2'b00}) begin
        errors++;
        $display("FAIL abort[%0d]: got %0d/%b/%b want 0/0/0",
                 i, cnt, busy, ready);
      end
      step(0, 0, 0, 0, 0);
      rcnt += int'(ready);
    end
    checks++;
    if (rcnt != 0) begin
      errors++;
      $display("FAIL abort_ready: pulses=%0d want 0", rcnt);
    end
    step(1, 0, 0, 1, 8);
    step(0, 0, 0, 0, 0);
    #2 clr_n = 0;
    #1;
    checks++;
    if ({cnt, busy, ready, last} !== {W'(0), 3'b000}) begin
      errors++;
      $display("FAIL async_clr: got %0d/%b/%b/%b want 0/0/0/0",
               cnt, busy, ready, last);
    end
    m_reset();
    @(negedge clk);
    clr_n = 1;
    @(negedge clk);
  endtask

  task automatic test_random();
    bit st, ab, sl, md;
    int nv;
    for (int i = 0; i < 400; i++) begin
      st = ($urandom_range(0, 2) == 0);
      ab = ($urandom_range(0, 19) == 0);
      sl = ($urandom_range(0, 3) == 0);
      md = 1'($urandom_range(0, 1));
      nv = ($urandom_range(0, 9) == 0) ? 63 : int'($urandom_range(0, 9));
      step(st, ab, sl, md, nv);
      checks++;
      if ({cnt, busy, ready, obs_last} !==
          {m_cnt(), m_act, m_ready, exp_last}) begin
        errors++;
        $display("FAIL random[%0d]: got %0d/%b/%b/%b want %0d/%b/%b/%b",
                 i, cnt, busy, ready, obs_last,
                 m_cnt(), m_act, m_ready, exp_last);
      end
    end
    while (m_act) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  task automatic test_width4_full();
    n4 = 4'd15;
    s4_start = 1;
    step(0, 0, 0, 0, 0);
    s4_start = 0;
    n4 = 4'd3;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (cnt4 !== 4'(i) || busy4 !== 1'b1 || ready4 !== 1'b0 ||
          last4 !== (i == 15)) begin
        errors++;
        $display("FAIL w4[%0d]: got %0d/%b/%b/%b want %0d/1/0/%b",
                 i, cnt4, busy4, ready4, last4, i, i == 15);
      end
      step(0, 0, 0, 0, 0);
    end
    checks++;
    if ({cnt4, busy4, ready4} !== {4'd15, 2'b01}) begin
      errors++;
      $display("FAIL w4_end: got %0d/%b/%b want 15/0/1", cnt4, busy4, ready4);
    end
    step(0, 0, 0, 0, 0);
    checks++;
    if ({cnt4, busy4, ready4} !== {4'd15, 2'b00}) begin
      errors++;
      $display("FAIL w4_hold: got %0d/%b/%b want 15/0/0", cnt4, busy4, ready4);
    end
  endtask

  initial begin
    fork
      begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
      end
    join_none
    test_reset();
    test_up_basic();
    test_down_stall();
    test_back_to_back();
    test_start_busy();
    test_abort_reset();
    test_random();
    test_width4_full();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
